// File: rtl/pzcorebus_pkg.sv
// Shared types and helpers for the pzcorebus response arbiter.
// Holds the arbiter FSM state encoding and the round-robin pointer advance.
package pzcorebus_pkg;

  typedef enum logic {
    IDLE,
    LOCKED
  } pzcorebus_response_arbiter_state_e;

  function automatic int rr_next_index(input int index, input int n);
    return (index + 1 >= n) ? 0 : index + 1;
  endfunction

endpackage

// File: rtl/pzcorebus_response_arbiter_rr.sv
// Rotating-priority one-hot grant: first set request at or above pointer, wrapping.
// Purely combinational; no backpressure of its own.
module pzcorebus_response_arbiter_rr #(
  parameter int N           = 2,
  parameter int INDEX_WIDTH = $clog2(N)
) (
  input  logic [N-1:0]           request,
  input  logic [INDEX_WIDTH-1:0] pointer,
  output logic [N-1:0]           grant
);

  logic                   found;
  int                     sum;
  logic [INDEX_WIDTH-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    sum   = 0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      sum = int'(pointer) + i;
      if (sum >= N) sum = sum - N;
      idx = INDEX_WIDTH'(sum);
      if (!found && request[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pzcorebus_response_arbiter.sv
// Merges N response streams round-robin per message; 1-cycle registered output, stalls all requesters while the output is held.
// Optional per-requester beat counters under PZCOREBUS_RESPONSE_ARBITER_STATS_EN.
module pzcorebus_response_arbiter
  import pzcorebus_pkg::*;
#(
  parameter int N           = 2,
  parameter int WIDTH       = 32,
  parameter int INDEX_WIDTH = $clog2(N)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [N-1:0]           i_valid,
  output logic [N-1:0]           o_ready,
  input  logic [N*WIDTH-1:0]     i_data,
  input  logic [N-1:0]           i_last,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_last,
`ifdef PZCOREBUS_RESPONSE_ARBITER_STATS_EN
  input  logic                   i_stats_clear,
  output logic [N*16-1:0]        o_beat_count,
`endif
  output logic [INDEX_WIDTH-1:0] o_index
);

  pzcorebus_response_arbiter_state_e state_q, state_d;
  logic [INDEX_WIDTH-1:0] ptr_q, ptr_d;
  logic [INDEX_WIDTH-1:0] lock_q, lock_d;

  logic [N-1:0]           rr_grant;
  logic [N-1:0]           grant;
  logic [INDEX_WIDTH-1:0] rr_index;
  logic [INDEX_WIDTH-1:0] cur_index;
  logic                   load;
  logic                   xfer;
  logic [WIDTH-1:0]       req_data [N];

  for (genvar k = 0; k < N; k++) begin : g_unpack
    assign req_data[k] = i_data[k*WIDTH +: WIDTH];
  end

  pzcorebus_response_arbiter_rr #(
    .N           (N),
    .INDEX_WIDTH (INDEX_WIDTH)
  ) u_rr (
    .request (i_valid),
    .pointer (ptr_q),
    .grant   (rr_grant)
  );

  always_comb begin
    rr_index = '0;
    for (int k = 0; k < N; k++) begin
      if (rr_grant[k]) rr_index = INDEX_WIDTH'(k);
    end
  end

  // A locked message keeps its grant even while its requester is idle.
  always_comb begin
    grant     = '0;
    cur_index = rr_index;
    if (state_q == LOCKED) begin
      cur_index     = lock_q;
      grant[lock_q] = 1'b1;
    end else begin
      grant = rr_grant;
    end
  end

  assign load    = !o_valid || i_ready;
  assign o_ready = (load && i_rst_n) ? grant : '0;
  assign xfer    = |(i_valid & o_ready);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    lock_d  = lock_q;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          if (i_last[cur_index]) begin
            ptr_d = INDEX_WIDTH'(rr_next_index(int'(cur_index), N));
          end else begin
            state_d = LOCKED;
            lock_d  = cur_index;
          end
        end
      end
      LOCKED: begin
        if (xfer && i_last[lock_q]) begin
          state_d = IDLE;
          ptr_d   = INDEX_WIDTH'(rr_next_index(int'(lock_q), N));
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      lock_q  <= lock_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_last  <= 1'b0;
      o_index <= '0;
    end else if (load) begin
      o_valid <= xfer;
      if (xfer) begin
        o_data  <= req_data[cur_index];
        o_last  <= i_last[cur_index];
        o_index <= cur_index;
      end
    end
  end

`ifdef PZCOREBUS_RESPONSE_ARBITER_STATS_EN
  for (genvar k = 0; k < N; k++) begin : g_stats
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        o_beat_count[k*16 +: 16] <= '0;
      end else if (i_stats_clear) begin
        o_beat_count[k*16 +: 16] <= '0;
      end else if (i_valid[k] && o_ready[k]) begin
        o_beat_count[k*16 +: 16] <= o_beat_count[k*16 +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pzcorebus_response_arbiter.sv
// Directed bench for pzcorebus_response_arbiter with N=4, WIDTH=32.
module tb_pzcorebus_response_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int IW = 2;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    valid;
  logic [N-1:0]    ready_out;
  logic [N*W-1:0]  data;
  logic [N-1:0]    last;
  logic            o_valid;
  logic            ready_in;
  logic [W-1:0]    o_data;
  logic            o_last;
  logic [IW-1:0]   o_index;
`ifdef PZCOREBUS_RESPONSE_ARBITER_STATS_EN
  logic            stats_clear;
  logic [N*16-1:0] beat_count;
`endif

  int total = 0;
  int bad   = 0;

  pzcorebus_response_arbiter #(.N(N), .WIDTH(W)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_valid       (valid),
    .o_ready       (ready_out),
    .i_data        (data),
    .i_last        (last),
    .o_valid       (o_valid),
    .i_ready       (ready_in),
    .o_data        (o_data),
    .o_last        (o_last),
`ifdef PZCOREBUS_RESPONSE_ARBITER_STATS_EN
    .i_stats_clear (stats_clear),
    .o_beat_count  (beat_count),
`endif
    .o_index       (o_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int k, input logic [W-1:0] d);
    data[k*W +: W] = d;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; valid = '0; last = '0; data = '0; ready_in = 1'b1;
`ifdef PZCOREBUS_RESPONSE_ARBITER_STATS_EN
    stats_clear = 1'b0;
`endif
    #2;
    total++;
    if (o_valid !== 1'b0 || o_data !== '0 || o_last !== 1'b0 || o_index !== '0 || ready_out !== '0) begin
      bad++;
      $display("FAIL reset_values: valid=%b data=%h last=%b index=%0d ready=%b, want all zero",
               o_valid, o_data, o_last, o_index, ready_out);
    end
    tick; tick;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick;
      total++;
      if (o_valid !== 1'b0 || ready_out !== 4'b0000 || o_index !== 2'd0) begin
        bad++;
        $display("FAIL idle_after_reset cyc %0d: valid=%b ready=%b index=%0d, want 0/0000/0",
                 i, o_valid, ready_out, o_index);
      end
    end
  endtask

  task automatic test_round_robin;
    int e;
    for (int k = 0; k < N; k++) set_data(k, 32'hA000_0000 + k);
    valid = 4'hF; last = 4'hF;
    #1;
    for (int i = 0; i < 6; i++) begin
      e = i % 4;
      total++;
      if (ready_out !== 4'(1 << e)) begin
        bad++;
        $display("FAIL rr_ready beat %0d: got %b want %b", i, ready_out, 4'(1 << e));
      end
      tick;
      total++;
      if (o_valid !== 1'b1 || o_index !== IW'(e) || o_data !== 32'hA000_0000 + e || o_last !== 1'b1) begin
        bad++;
        $display("FAIL rr_out beat %0d: valid=%b index=%0d data=%h, want 1/%0d/%h",
                 i, o_valid, o_index, o_data, e, 32'hA000_0000 + e);
      end
    end
    valid = '0;
    tick;
    total++;
    if (o_valid !== 1'b0) begin
      bad++;
      $display("FAIL rr_drain: o_valid=%b want 0", o_valid);
    end
  endtask

  // Pointer is 2 on entry: requester 1 starts alone, then 0 and 2 join while it is locked.
  task automatic test_locked_message;
    logic [N-1:0]  v_tab   [8] = '{4'b0010, 4'b0111, 4'b0101, 4'b0111, 4'b0111, 4'b0101, 4'b0001, 4'b0000};
    logic [N-1:0]  l_tab   [8] = '{4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0111, 4'b0101, 4'b0101, 4'b0101};
    logic [N-1:0]  r_tab   [8] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b0001, 4'b0000};
    logic          ov_tab  [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [IW-1:0] ix_tab  [8] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd0, 2'd0};
    logic [W-1:0]  dt_tab  [8] = '{32'h1000_0001, 32'h1000_0002, 32'h1000_0002, 32'h1000_0003,
                                   32'h1000_0004, 32'hB000_0002, 32'hB000_0000, 32'hB000_0000};
    logic          ol_tab  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    int beat;
    beat = 1;
    set_data(0, 32'hB000_0000);
    set_data(2, 32'hB000_0002);
    for (int c = 0; c < 8; c++) begin
      valid = v_tab[c];
      last  = l_tab[c];
      set_data(1, 32'h1000_0000 + beat);
      #1;
      total++;
      if (ready_out !== r_tab[c]) begin
        bad++;
        $display("FAIL lock_ready cyc %0d: got %b want %b", c, ready_out, r_tab[c]);
      end
      if (valid[1] && ready_out[1]) beat++;
      tick;
      total++;
      if (o_valid !== ov_tab[c] || (ov_tab[c] && (o_index !== ix_tab[c] || o_data !== dt_tab[c] || o_last !== ol_tab[c]))) begin
        bad++;
        $display("FAIL lock_out cyc %0d: valid=%b index=%0d data=%h last=%b, want %b/%0d/%h/%b",
                 c, o_valid, o_index, o_data, o_last, ov_tab[c], ix_tab[c], dt_tab[c], ol_tab[c]);
      end
    end
  endtask

  task automatic test_backpressure;
    set_data(0, 32'hC000_0000);
    set_data(2, 32'hC000_0002);
    valid = 4'b0101; last = 4'hF; ready_in = 1'b1;
    #1;
    total++;
    if (ready_out !== 4'b0100) begin
      bad++;
      $display("FAIL bp_first_ready: got %b want 0100", ready_out);
    end
    tick;
    ready_in = 1'b0;
    valid    = 4'b0001;
    #1;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (ready_out !== 4'b0000 || o_valid !== 1'b1 || o_index !== 2'd2 || o_data !== 32'hC000_0002) begin
        bad++;
        $display("FAIL bp_hold cyc %0d: ready=%b valid=%b index=%0d data=%h, want 0000/1/2/c0000002",
                 i, ready_out, o_valid, o_index, o_data);
      end
      tick;
    end
    ready_in = 1'b1;
    #1;
    total++;
    if (ready_out !== 4'b0001) begin
      bad++;
      $display("FAIL bp_release_ready: got %b want 0001", ready_out);
    end
    tick;
    total++;
    if (o_valid !== 1'b1 || o_index !== 2'd0 || o_data !== 32'hC000_0000) begin
      bad++;
      $display("FAIL bp_resume: valid=%b index=%0d data=%h, want 1/0/c0000000", o_valid, o_index, o_data);
    end
    valid = '0;
    tick;
    total++;
    if (o_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_drain: o_valid=%b want 0", o_valid);
    end
  endtask

  task automatic test_reset_mid_message;
    valid = 4'b1000; last = 4'b0000;
    set_data(3, 32'h3000_0001);
    #1;
    total++;
    if (ready_out !== 4'b1000) begin
      bad++;
      $display("FAIL rst_msg_ready: got %b want 1000", ready_out);
    end
    tick;
    total++;
    if (o_valid !== 1'b1 || o_index !== 2'd3 || o_data !== 32'h3000_0001) begin
      bad++;
      $display("FAIL rst_msg_beat1: valid=%b index=%0d data=%h, want 1/3/30000001", o_valid, o_index, o_data);
    end
    set_data(3, 32'h3000_0002);
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (o_valid !== 1'b0 || o_data !== '0 || o_index !== '0 || o_last !== 1'b0 || ready_out !== '0) begin
      bad++;
      $display("FAIL rst_msg_clear: valid=%b data=%h index=%0d last=%b ready=%b, want all zero",
               o_valid, o_data, o_index, o_last, ready_out);
    end
    valid = 4'b1110; last = 4'hF;
    set_data(1, 32'hD000_0001);
    tick;
    rst_n = 1'b1;
    #1;
    total++;
    if (ready_out !== 4'b0010) begin
      bad++;
      $display("FAIL rst_restart_ready: got %b want 0010", ready_out);
    end
    tick;
    total++;
    if (o_valid !== 1'b1 || o_index !== 2'd1 || o_data !== 32'hD000_0001) begin
      bad++;
      $display("FAIL rst_restart_out: valid=%b index=%0d data=%h, want 1/1/d0000001", o_valid, o_index, o_data);
    end
    valid = '0;
    tick;
  endtask

`ifdef PZCOREBUS_RESPONSE_ARBITER_STATS_EN
  task automatic test_stats;
    valid = 4'b0001; last = 4'hF;
    for (int i = 0; i < 16'hFFFF; i++) tick;
    total++;
    if (beat_count[15:0] !== 16'hFFFF) begin
      bad++;
      $display("FAIL stats_ffff: got %h want ffff", beat_count[15:0]);
    end
    tick;
    total++;
    if (beat_count[15:0] !== 16'h0000 || beat_count[31:16] !== 16'h0001) begin
      bad++;
      $display("FAIL stats_wrap: cnt0=%h cnt1=%h, want 0000/0001", beat_count[15:0], beat_count[31:16]);
    end
    tick;
    stats_clear = 1'b1;
    tick;
    stats_clear = 1'b0;
    total++;
    if (beat_count !== '0) begin
      bad++;
      $display("FAIL stats_clear_wins: got %h want 0", beat_count);
    end
    tick;
    total++;
    if (beat_count[15:0] !== 16'h0001) begin
      bad++;
      $display("FAIL stats_after_clear: got %h want 0001", beat_count[15:0]);
    end
    valid = '0;
    tick;
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_locked_message();
    test_backpressure();
    test_reset_mid_message();
`ifdef PZCOREBUS_RESPONSE_ARBITER_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
